// File: rtl/tl_ul_a_arbiter_2to1.sv
// tl_ul_a_arbiter_2to1
// Lets two TileLink-UL masters share one 32-bit TL-UL slave port.
//   - A channel: round-robin arbitration between the eligible masters. A beat
//     that is presented but stalled keeps its grant until it fires.
//   - The outbound source ID is {master_idx, master_source}. D responses are
//     routed back to a master by that tag bit, and the tag is stripped again.
//   - Each master may have at most MAX_OUT requests outstanding.
// Ports:
//   clock, reset_n         : clock (rising edge); asynchronous active-low reset
//   m0_a_* / m1_a_*        : master A request channels (valid/ready + payload)
//   m0_d_* / m1_d_*        : master D response channels (valid/ready + payload)
//   s_a_*                  : slave A channel (source is SRC_W+1 bits wide)
//   s_d_*                  : slave D channel (source is SRC_W+1 bits wide)
// The A and D paths are combinational; only arbitration state is registered.
module tl_ul_a_arbiter_2to1 #(
  parameter int SRC_W   = 3,
  parameter int SZ_W    = 2,
  parameter int MAX_OUT = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  // master 0 A
  input  logic               m0_a_valid,
  output logic               m0_a_ready,
  input  logic [2:0]         m0_a_opcode,
  input  logic [2:0]         m0_a_param,
  input  logic [SZ_W-1:0]    m0_a_size,
  input  logic [SRC_W-1:0]   m0_a_source,
  input  logic [31:0]        m0_a_address,
  input  logic [3:0]         m0_a_mask,
  input  logic [31:0]        m0_a_data,
  input  logic               m0_a_corrupt,
  // master 1 A
  input  logic               m1_a_valid,
  output logic               m1_a_ready,
  input  logic [2:0]         m1_a_opcode,
  input  logic [2:0]         m1_a_param,
  input  logic [SZ_W-1:0]    m1_a_size,
  input  logic [SRC_W-1:0]   m1_a_source,
  input  logic [31:0]        m1_a_address,
  input  logic [3:0]         m1_a_mask,
  input  logic [31:0]        m1_a_data,
  input  logic               m1_a_corrupt,
  // master 0 D
  output logic               m0_d_valid,
  input  logic               m0_d_ready,
  output logic [2:0]         m0_d_opcode,
  output logic [1:0]         m0_d_param,
  output logic [SZ_W-1:0]    m0_d_size,
  output logic [SRC_W-1:0]   m0_d_source,
  output logic               m0_d_denied,
  output logic [31:0]        m0_d_data,
  output logic               m0_d_corrupt,
  // master 1 D
  output logic               m1_d_valid,
  input  logic               m1_d_ready,
  output logic [2:0]         m1_d_opcode,
  output logic [1:0]         m1_d_param,
  output logic [SZ_W-1:0]    m1_d_size,
  output logic [SRC_W-1:0]   m1_d_source,
  output logic               m1_d_denied,
  output logic [31:0]        m1_d_data,
  output logic               m1_d_corrupt,
  // slave A
  output logic               s_a_valid,
  input  logic               s_a_ready,
  output logic [2:0]         s_a_opcode,
  output logic [2:0]         s_a_param,
  output logic [SZ_W-1:0]    s_a_size,
  output logic [SRC_W:0]     s_a_source,
  output logic [31:0]        s_a_address,
  output logic [3:0]         s_a_mask,
  output logic [31:0]        s_a_data,
  output logic               s_a_corrupt,
  // slave D
  input  logic               s_d_valid,
  output logic               s_d_ready,
  input  logic [2:0]         s_d_opcode,
  input  logic [1:0]         s_d_param,
  input  logic [SZ_W-1:0]    s_d_size,
  input  logic [SRC_W:0]     s_d_source,
  input  logic               s_d_denied,
  input  logic [31:0]        s_d_data,
  input  logic               s_d_corrupt
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  // Outstanding-count update. The increment is applied first, so an A fire
  // and a D fire on the same master in the same cycle cancel out. A D beat
  // with nothing outstanding leaves the count at zero.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W-1:0] tmp;
    tmp = cnt + CNT_W'(inc);
    if (dec && (tmp != {CNT_W{1'b0}})) begin
      tmp = tmp - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      tmp = tmp;
    end
    return tmp;
  endfunction

  logic             rr_r;
  logic             lock_r;
  logic             lock_idx_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  logic elig0_s;
  logic elig1_s;
  logic grant_vld_s;
  logic grant_s;
  logic grant_elig_s;
  logic a_fire_s;
  logic d_idx_s;
  logic d_fire_s;

  // Grant selection: a held (stalled) beat wins, otherwise round-robin on a tie.
  always_comb begin
    elig0_s     = m0_a_valid && (cnt0_r < MAX_CNT);
    elig1_s     = m1_a_valid && (cnt1_r < MAX_CNT);
    grant_vld_s = 1'b0;
    grant_s     = 1'b0;
    if (lock_r) begin
      grant_vld_s = 1'b1;
      grant_s     = lock_idx_r;
    end else if (elig0_s && elig1_s) begin
      grant_vld_s = 1'b1;
      grant_s     = rr_r;
    end else if (elig0_s) begin
      grant_vld_s = 1'b1;
      grant_s     = 1'b0;
    end else if (elig1_s) begin
      grant_vld_s = 1'b1;
      grant_s     = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_s     = 1'b0;
    end
    grant_elig_s = grant_s ? elig1_s : elig0_s;
  end

  // Handshakes are gated by reset_n so they drop as soon as reset asserts.
  assign s_a_valid  = reset_n && grant_vld_s && grant_elig_s;
  assign a_fire_s   = s_a_valid && s_a_ready;
  assign m0_a_ready = s_a_valid && s_a_ready && !grant_s;
  assign m1_a_ready = s_a_valid && s_a_ready && grant_s;

  // A payload mux. It follows the grant even when nothing is valid.
  always_comb begin
    if (grant_s) begin
      s_a_opcode  = m1_a_opcode;
      s_a_param   = m1_a_param;
      s_a_size    = m1_a_size;
      s_a_source  = {1'b1, m1_a_source};
      s_a_address = m1_a_address;
      s_a_mask    = m1_a_mask;
      s_a_data    = m1_a_data;
      s_a_corrupt = m1_a_corrupt;
    end else begin
      s_a_opcode  = m0_a_opcode;
      s_a_param   = m0_a_param;
      s_a_size    = m0_a_size;
      s_a_source  = {1'b0, m0_a_source};
      s_a_address = m0_a_address;
      s_a_mask    = m0_a_mask;
      s_a_data    = m0_a_data;
      s_a_corrupt = m0_a_corrupt;
    end
  end

  // D routing: the top source bit selects the master; the payload goes to both.
  assign d_idx_s    = s_d_source[SRC_W];
  assign m0_d_valid = reset_n && s_d_valid && !d_idx_s;
  assign m1_d_valid = reset_n && s_d_valid && d_idx_s;
  assign s_d_ready  = reset_n && (d_idx_s ? m1_d_ready : m0_d_ready);
  assign d_fire_s   = s_d_valid && s_d_ready;

  assign m0_d_opcode  = s_d_opcode;
  assign m0_d_param   = s_d_param;
  assign m0_d_size    = s_d_size;
  assign m0_d_source  = s_d_source[SRC_W-1:0];
  assign m0_d_denied  = s_d_denied;
  assign m0_d_data    = s_d_data;
  assign m0_d_corrupt = s_d_corrupt;
  assign m1_d_opcode  = s_d_opcode;
  assign m1_d_param   = s_d_param;
  assign m1_d_size    = s_d_size;
  assign m1_d_source  = s_d_source[SRC_W-1:0];
  assign m1_d_denied  = s_d_denied;
  assign m1_d_data    = s_d_data;
  assign m1_d_corrupt = s_d_corrupt;

  // Arbitration state: round-robin pointer, stall lock and outstanding counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_r       <= 1'b0;
      lock_r     <= 1'b0;
      lock_idx_r <= 1'b0;
      cnt0_r     <= {CNT_W{1'b0}};
      cnt1_r     <= {CNT_W{1'b0}};
    end else begin
      if (a_fire_s) begin
        rr_r   <= ~grant_s;
        lock_r <= 1'b0;
      end else if (s_a_valid) begin
        // Stalled beat: keep the grant until it is accepted.
        lock_r     <= 1'b1;
        lock_idx_r <= grant_s;
      end else begin
        // Nothing presented, so there is nothing to hold.
        lock_r <= 1'b0;
      end
      cnt0_r <= cnt_next(cnt0_r, a_fire_s && !grant_s, d_fire_s && !d_idx_s);
      cnt1_r <= cnt_next(cnt1_r, a_fire_s && grant_s, d_fire_s && d_idx_s);
    end
  end

endmodule

// File: tb/tb_tl_ul_a_arbiter_2to1.sv
module tb_tl_ul_a_arbiter_2to1;

  localparam int SRC_W   = 3;
  localparam int SZ_W    = 2;
  localparam int MAX_OUT = 4;
  localparam int NCYC    = 3000;

  typedef struct packed {
    logic [2:0]       op;
    logic [2:0]       param;
    logic [SZ_W-1:0]  size;
    logic [SRC_W-1:0] src;
    logic [31:0]      addr;
    logic [3:0]       mask;
    logic [31:0]      data;
    logic             corrupt;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [1:0]       param;
    logic [SZ_W-1:0]  size;
    logic [SRC_W-1:0] src;
    logic             denied;
    logic [31:0]      data;
    logic             corrupt;
  } d_beat_t;

  logic clock;
  logic reset_n;

  // Stimulus state
  a_beat_t m_beat [2];
  logic    m_pres [2];
  logic    m_dr   [2];
  logic    sa_ready;
  logic    sd_valid;
  logic    sd_tag;
  d_beat_t sd_beat;

  // Scoreboard queues
  a_beat_t exp_a0 [$];
  a_beat_t exp_a1 [$];
  d_beat_t exp_d0 [$];
  d_beat_t exp_d1 [$];
  logic    pend [$];

  int n_cmp;
  int n_bad;

  // DUT wires
  logic m0_a_ready, m1_a_ready;
  logic m0_d_valid, m1_d_valid;
  logic [2:0] m0_d_opcode, m1_d_opcode;
  logic [1:0] m0_d_param, m1_d_param;
  logic [SZ_W-1:0] m0_d_size, m1_d_size;
  logic [SRC_W-1:0] m0_d_source, m1_d_source;
  logic m0_d_denied, m1_d_denied, m0_d_corrupt, m1_d_corrupt;
  logic [31:0] m0_d_data, m1_d_data;
  logic s_a_valid, s_d_ready, s_a_corrupt;
  logic [2:0] s_a_opcode, s_a_param;
  logic [SZ_W-1:0] s_a_size;
  logic [SRC_W:0] s_a_source;
  logic [31:0] s_a_address, s_a_data;
  logic [3:0] s_a_mask;

  tl_ul_a_arbiter_2to1 #(.SRC_W(SRC_W), .SZ_W(SZ_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_a_valid(m_pres[0]), .m0_a_ready(m0_a_ready),
    .m0_a_opcode(m_beat[0].op), .m0_a_param(m_beat[0].param), .m0_a_size(m_beat[0].size),
    .m0_a_source(m_beat[0].src), .m0_a_address(m_beat[0].addr), .m0_a_mask(m_beat[0].mask),
    .m0_a_data(m_beat[0].data), .m0_a_corrupt(m_beat[0].corrupt),
    .m1_a_valid(m_pres[1]), .m1_a_ready(m1_a_ready),
    .m1_a_opcode(m_beat[1].op), .m1_a_param(m_beat[1].param), .m1_a_size(m_beat[1].size),
    .m1_a_source(m_beat[1].src), .m1_a_address(m_beat[1].addr), .m1_a_mask(m_beat[1].mask),
    .m1_a_data(m_beat[1].data), .m1_a_corrupt(m_beat[1].corrupt),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m_dr[0]),
    .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param), .m0_d_size(m0_d_size),
    .m0_d_source(m0_d_source), .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data),
    .m0_d_corrupt(m0_d_corrupt),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m_dr[1]),
    .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param), .m1_d_size(m1_d_size),
    .m1_d_source(m1_d_source), .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data),
    .m1_d_corrupt(m1_d_corrupt),
    .s_a_valid(s_a_valid), .s_a_ready(sa_ready),
    .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
    .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
    .s_a_data(s_a_data), .s_a_corrupt(s_a_corrupt),
    .s_d_valid(sd_valid), .s_d_ready(s_d_ready),
    .s_d_opcode(sd_beat.op), .s_d_param(sd_beat.param), .s_d_size(sd_beat.size),
    .s_d_source({sd_tag, sd_beat.src}), .s_d_denied(sd_beat.denied),
    .s_d_data(sd_beat.data), .s_d_corrupt(sd_beat.corrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic missing(input string name);
    n_cmp = n_cmp + 1;
    n_bad = n_bad + 1;
    $display("FAIL %s actual=no-entry required=entry at %0t", name, $time);
  endtask

  // ---------------- reference model + monitor ----------------
  // The model tracks, per master, how many requests are in flight, which
  // master should win a tie next, and which master owns a beat that was
  // offered but not yet taken.
  int      out_cnt [2];
  int      tie_pref;
  int      owner;
  a_beat_t act_a;
  d_beat_t act_d;
  d_beat_t exp_d;
  a_beat_t exp_a;

  initial begin
    out_cnt[0] = 0;
    out_cnt[1] = 0;
    tie_pref   = 0;
    owner      = -1;
  end

  always @(negedge clock) begin
    bit el [2];
    int win;
    bit exp_sv, afire, dfire;
    int idx;
    if (!reset_n) begin
      chk("rst_s_a_valid", {127'd0, s_a_valid}, 128'd0);
      chk("rst_m_a_ready", {126'd0, m1_a_ready, m0_a_ready}, 128'd0);
      chk("rst_m_d_valid", {126'd0, m1_d_valid, m0_d_valid}, 128'd0);
      chk("rst_s_d_ready", {127'd0, s_d_ready}, 128'd0);
      out_cnt[0] = 0;
      out_cnt[1] = 0;
      tie_pref   = 0;
      owner      = -1;
    end else begin
      for (int m = 0; m < 2; m++) el[m] = m_pres[m] && (out_cnt[m] < MAX_OUT);
      if (owner >= 0)           win = owner;
      else if (el[0] && el[1])  win = tie_pref;
      else if (el[0])           win = 0;
      else if (el[1])           win = 1;
      else                      win = -1;
      exp_sv = (win >= 0) && el[win];
      chk("s_a_valid", {127'd0, s_a_valid}, {127'd0, exp_sv});
      if (exp_sv) chk("grant_tag", {127'd0, s_a_source[SRC_W]}, 128'(win));
      chk("m0_a_ready", {127'd0, m0_a_ready}, {127'd0, exp_sv && win == 0 && sa_ready});
      chk("m1_a_ready", {127'd0, m1_a_ready}, {127'd0, exp_sv && win == 1 && sa_ready});
      afire = exp_sv && sa_ready;
      if (afire) begin
        act_a = '{s_a_opcode, s_a_param, s_a_size, s_a_source[SRC_W-1:0],
                  s_a_address, s_a_mask, s_a_data, s_a_corrupt};
        if (win == 0 && exp_a0.size() > 0) begin
          exp_a = exp_a0.pop_front();
          chk("a_payload_m0", 128'(act_a), 128'(exp_a));
        end else if (win == 1 && exp_a1.size() > 0) begin
          exp_a = exp_a1.pop_front();
          chk("a_payload_m1", 128'(act_a), 128'(exp_a));
        end else begin
          missing("a_scoreboard");
        end
      end
      // D channel
      idx = int'(sd_tag);
      chk("m0_d_valid", {127'd0, m0_d_valid}, {127'd0, sd_valid && idx == 0});
      chk("m1_d_valid", {127'd0, m1_d_valid}, {127'd0, sd_valid && idx == 1});
      chk("s_d_ready", {127'd0, s_d_ready}, {127'd0, m_dr[idx]});
      dfire = sd_valid && m_dr[idx];
      if (dfire) begin
        if (idx == 0) act_d = '{m0_d_opcode, m0_d_param, m0_d_size, m0_d_source,
                                m0_d_denied, m0_d_data, m0_d_corrupt};
        else          act_d = '{m1_d_opcode, m1_d_param, m1_d_size, m1_d_source,
                                m1_d_denied, m1_d_data, m1_d_corrupt};
        if (idx == 0 && exp_d0.size() > 0) begin
          exp_d = exp_d0.pop_front();
          chk("d_payload_m0", 128'(act_d), 128'(exp_d));
        end else if (idx == 1 && exp_d1.size() > 0) begin
          exp_d = exp_d1.pop_front();
          chk("d_payload_m1", 128'(act_d), 128'(exp_d));
        end else begin
          missing("d_scoreboard");
        end
      end
      // advance the model to the next cycle
      if (afire) begin
        owner        = -1;
        tie_pref     = 1 - win;
        out_cnt[win] = out_cnt[win] + 1;
      end else if (exp_sv) begin
        owner = win;
      end else begin
        owner = -1;
      end
      if (dfire && out_cnt[idx] > 0) out_cnt[idx] = out_cnt[idx] - 1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int pv, pr, pd, pdr;
    bit d_on;
    bit mf [2];
    bit afire, dfire;
    logic atag;
    int k;
    a_beat_t nb;
    n_cmp    = 0;
    n_bad    = 0;
    reset_n  = 1'b0;
    sa_ready = 1'b0;
    sd_valid = 1'b0;
    sd_tag   = 1'b0;
    sd_beat  = '0;
    for (int m = 0; m < 2; m++) begin
      m_pres[m] = 1'b0;
      m_beat[m] = '0;
      m_dr[m]   = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clock);
      #1;
      mf[0] = m_pres[0] && m0_a_ready;
      mf[1] = m_pres[1] && m1_a_ready;
      afire = s_a_valid && sa_ready;
      atag  = s_a_source[SRC_W];
      dfire = sd_valid && s_d_ready;
      @(posedge clock);
      #1;
      if (cyc < 500)       begin pv = 50;  pr = 70;  pd = 40; pdr = 70;  d_on = 1'b1; end
      else if (cyc < 900)  begin pv = 100; pr = 100; pd = 80; pdr = 100; d_on = 1'b1; end
      else if (cyc < 1100) begin pv = 80;  pr = 80;  pd = 0;  pdr = 80;  d_on = 1'b0; end
      else if (cyc < 1500) begin pv = 100; pr = 30;  pd = 50; pdr = 60;  d_on = 1'b1; end
      else                 begin pv = 60;  pr = 60;  pd = 50; pdr = 60;  d_on = 1'b1; end
      if (cyc == 1503) reset_n = 1'b1;
      for (int m = 0; m < 2; m++) begin
        if (mf[m]) m_pres[m] = 1'b0;
        if (!m_pres[m] && ($urandom_range(99) < 32'(pv))) begin
          nb.op      = 3'($urandom_range(7));
          nb.param   = 3'($urandom_range(7));
          nb.size    = SZ_W'($urandom_range(3));
          nb.src     = SRC_W'($urandom_range(7));
          nb.addr    = $urandom;
          nb.mask    = 4'($urandom_range(15));
          nb.data    = $urandom;
          nb.corrupt = 1'($urandom_range(1));
          m_beat[m]  = nb;
          m_pres[m]  = 1'b1;
          if (m == 0) exp_a0.push_back(nb);
          else        exp_a1.push_back(nb);
        end
        m_dr[m] = ($urandom_range(99) < 32'(pdr));
      end
      if (afire) pend.push_back(atag);
      if (dfire) sd_valid = 1'b0;
      if (!sd_valid && d_on) begin
        if (pend.size() > 0 && ($urandom_range(99) < 32'(pd))) begin
          k = int'($urandom_range(pend.size() - 1));
          sd_tag = pend[k];
          pend.delete(k);
          sd_valid = 1'b1;
        end else if (pend.size() == 0 && ($urandom_range(99) < 32'd3)) begin
          // response with nothing outstanding for that master
          sd_tag   = 1'($urandom_range(1));
          sd_valid = 1'b1;
        end
        if (sd_valid) begin
          sd_beat.op      = 3'($urandom_range(7));
          sd_beat.param   = 2'($urandom_range(3));
          sd_beat.size    = SZ_W'($urandom_range(3));
          sd_beat.src     = SRC_W'($urandom_range(7));
          sd_beat.denied  = 1'($urandom_range(1));
          sd_beat.data    = $urandom;
          sd_beat.corrupt = 1'($urandom_range(1));
          if (sd_tag == 1'b0) exp_d0.push_back(sd_beat);
          else                exp_d1.push_back(sd_beat);
        end
      end
      sa_ready = ($urandom_range(99) < 32'(pr));
      if (cyc == 1500) begin
        // asynchronous reset in the middle of a cycle, with traffic present
        sa_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_s_a_valid", {127'd0, s_a_valid}, 128'd0);
        chk("async_rst_a_ready", {126'd0, m1_a_ready, m0_a_ready}, 128'd0);
        chk("async_rst_d_valid", {126'd0, m1_d_valid, m0_d_valid}, 128'd0);
        chk("async_rst_s_d_ready", {127'd0, s_d_ready}, 128'd0);
      end
    end
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
